stream_maxpool_relu: RTL and testbench



---
 rtl/stream_maxpool_relu_pkg.sv | 25 ++
 rtl/stream_maxpool_relu_if.sv | 29 ++
 rtl/stream_maxpool_relu_fifo.sv | 57 +++++
 rtl/stream_maxpool_relu.sv | 98 +++++++++
 tb/tb_stream_maxpool_relu.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/stream_maxpool_relu_pkg.sv
// Shared definitions for the streaming pooling layers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package stream_maxpool_relu_pkg;

  localparam int WIDTH_DEFAULT = 16;

  // Widest sample the helpers accept; callers sign-extend into this width.
  localparam int MAX_WIDTH = 64;

  // Signed maximum. Callers widen narrower samples with a signed size cast
  // so that full-range negative values keep their ordering.
  function automatic logic signed [MAX_WIDTH-1:0] smax(
    input logic signed [MAX_WIDTH-1:0] a,
    input logic signed [MAX_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // Pooled outputs per vector, counting the trailing partial window.
  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/stream_maxpool_relu_if.sv
// Stream bundle between a producer layer, the pooling block and the next layer.
// Latency: none (wiring only).
// Backpressure: s_ready_x / m_ready_y carry the valid-ready handshake on each side.
// Ports: s_data_in_x/s_valid_x/s_ready_x = input stream,
//        m_data_out_y/m_valid_y/m_ready_y = output stream.
interface stream_maxpool_relu_if
  import stream_maxpool_relu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] s_data_in_x;
  logic             s_valid_x;
  logic             s_ready_x;
  logic [WIDTH-1:0] m_data_out_y;
  logic             m_valid_y;
  logic             m_ready_y;

  // Pooling block side.
  modport slave (
    input  s_data_in_x, s_valid_x, m_ready_y,
    output s_ready_x, m_data_out_y, m_valid_y
  );

  // Environment side: drives input samples, consumes pooled results.
  modport master (
    output s_data_in_x, s_valid_x, m_ready_y,
    input  s_ready_x, m_data_out_y, m_valid_y
  );
endinterface

// File: rtl/stream_maxpool_relu_fifo.sv
// Small circular FIFO holding pooled results.
// Latency: a push at edge t is visible at the head after edge t.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: clk, reset (sync, active-high), push/push_data, pop,
//        head (raw storage at read pointer), full, empty, count.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stream_maxpool_relu.sv
// Streaming 1-D max-pool (window = stride = POOL) with optional ReLU clamp.
// Latency: result of a window-closing sample is at the FIFO head after that edge.
// Backpressure: stalls only on a window-closing sample while the FIFO is full.
// Ports: clk, reset (sync, active-high), io (slave side of the stream bundle).
module stream_maxpool_relu
  import stream_maxpool_relu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int LEN   = 15,
  parameter int POOL  = 2,
  parameter int DEPTH = 4,
  parameter int RELU  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_maxpool_relu_if.slave  io
);
  localparam int IW = (LEN > 1)  ? $clog2(LEN)  : 1;
  localparam int WW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [IW-1:0]           idx;
  logic [WW-1:0]           win;
  logic signed [WIDTH-1:0] run_max;
  logic signed [WIDTH-1:0] sample;
  logic signed [WIDTH-1:0] pooled;
  logic [WIDTH-1:0]        push_data;
  logic                    last_idx;
  logic                    comp;
  logic                    ready;
  logic                    accept;
  logic                    push;
  logic                    pop;

  logic [WIDTH-1:0]        fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [CW-1:0]           fifo_count;

  assign sample   = $signed(io.s_data_in_x);
  assign last_idx = (idx == IW'(LEN-1));
  // The last sample of a vector closes whatever partial window is open.
  assign comp     = (win == WW'(POOL-1)) || last_idx;

  // Registered state only: a non-closing sample never needs FIFO space.
  assign ready    = !comp || !fifo_full;
  assign accept   = io.s_valid_x && ready;
  assign push     = accept && comp;
  assign pop      = io.m_valid_y && io.m_ready_y;

  always_comb begin
    pooled    = sample;
    push_data = '0;
    if (win != '0) begin
      pooled = WIDTH'(smax(MAX_WIDTH'(run_max), MAX_WIDTH'(sample)));
    end
    if ((RELU != 0) && pooled[WIDTH-1]) begin
      push_data = '0;
    end else begin
      push_data = pooled;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      win     <= '0;
      run_max <= '0;
    end else if (accept) begin
      run_max <= pooled;
      if (last_idx) idx <= '0;
      else          idx <= idx + IW'(1);
      if (comp)     win <= '0;
      else          win <= win + WW'(1);
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign io.s_ready_x    = ready;
  assign io.m_valid_y    = (fifo_count != '0);
  // Unwritten storage must not leak out while the FIFO is empty.
  assign io.m_data_out_y = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_stream_maxpool_relu.sv
// Bench for stream_maxpool_relu: two instances (ReLU on / off) on one stimulus.
// Each cycle compares ready/valid/data against a window-list reference model.
// Directed phases check fixed result lists, extremes, backpressure and reset.
module tb_stream_maxpool_relu;
  localparam int W     = 16;
  localparam int LEN   = 15;
  localparam int POOL  = 2;
  localparam int DEPTH = 4;
  localparam int OUTS  = 8;   // ceil(15 / 2)

  logic                clk;
  logic                reset;
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                out_ready;

  stream_maxpool_relu_if #(.WIDTH(W)) if1 ();
  stream_maxpool_relu_if #(.WIDTH(W)) if0 ();

  assign if1.s_data_in_x = in_data;
  assign if1.s_valid_x   = in_valid;
  assign if1.m_ready_y   = out_ready;
  assign if0.s_data_in_x = in_data;
  assign if0.s_valid_x   = in_valid;
  assign if0.m_ready_y   = out_ready;

  stream_maxpool_relu #(.WIDTH(W), .LEN(LEN), .POOL(POOL), .DEPTH(DEPTH), .RELU(1)) dut1 (
    .clk (clk), .reset (reset), .io (if1.slave)
  );
  stream_maxpool_relu #(.WIDTH(W), .LEN(LEN), .POOL(POOL), .DEPTH(DEPTH), .RELU(0)) dut0 (
    .clk (clk), .reset (reset), .io (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: current window samples, position in vector,
  // results not yet consumed downstream.
  logic signed [W-1:0] cur[$];
  logic signed [W-1:0] q1[$];
  logic signed [W-1:0] q0[$];
  logic signed [W-1:0] stim[$];
  logic signed [W-1:0] popped1[$];
  logic signed [W-1:0] popped0[$];
  logic signed [W-1:0] want1[$];
  logic signed [W-1:0] want0[$];
  int pos;
  int accepted;
  int total;
  int fails;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_accept(input logic signed [W-1:0] x);
    logic signed [W-1:0] m;
    cur.push_back(x);
    pos++;
    if (cur.size() == POOL || pos == LEN) begin
      m = cur[0];
      foreach (cur[i]) if (cur[i] > m) m = cur[i];
      q0.push_back(m);
      q1.push_back((m < 0) ? 16'sd0 : m);
      cur.delete();
      if (pos == LEN) pos = 0;
    end
  endtask

  // One clock: inputs are already set; observe at the falling edge.
  task automatic tick();
    logic                exp_rdy;
    logic                exp_vld;
    logic signed [W-1:0] e1;
    logic signed [W-1:0] e0;
    logic signed [W-1:0] tmp;
    bit acc;
    bit pop;
    @(negedge clk);
    exp_rdy = !((cur.size() == POOL-1) || (pos == LEN-1)) || (q1.size() < DEPTH);
    exp_vld = (q1.size() != 0);
    e1 = exp_vld ? q1[0] : 16'sd0;
    e0 = exp_vld ? q0[0] : 16'sd0;
    chk("s_ready_x relu1", {31'd0, if1.s_ready_x}, {31'd0, exp_rdy});
    chk("s_ready_x relu0", {31'd0, if0.s_ready_x}, {31'd0, exp_rdy});
    chk("m_valid_y relu1", {31'd0, if1.m_valid_y}, {31'd0, exp_vld});
    chk("m_valid_y relu0", {31'd0, if0.m_valid_y}, {31'd0, exp_vld});
    chk("m_data_out_y relu1", $signed(if1.m_data_out_y), e1);
    chk("m_data_out_y relu0", $signed(if0.m_data_out_y), e0);
    acc = in_valid && if1.s_ready_x;
    pop = if1.m_valid_y && out_ready;
    if (pop && q1.size() != 0) begin
      popped1.push_back($signed(if1.m_data_out_y));
      popped0.push_back($signed(if0.m_data_out_y));
      tmp = q1.pop_front();
      tmp = q0.pop_front();
    end
    if (acc) begin
      model_accept(in_data);
      accepted++;
      if (stim.size() != 0) tmp = stim.pop_front();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int max_cycles, input int vld_pct, input int rdy_pct, input bit must_finish);
    int n;
    n = 0;
    while (stim.size() != 0 && n < max_cycles) begin
      in_data   = stim[0];
      in_valid  = ($urandom_range(99) < vld_pct);
      out_ready = ($urandom_range(99) < rdy_pct);
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (must_finish) chk("stimulus consumed (left)", stim.size(), 0);
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q1.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk("drain done (left)", q1.size(), 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    q1.delete(); q0.delete(); cur.delete();
    pos = 0;
  endtask

  task automatic chk_out(input string tag, input int n);
    chk({tag, " enough outputs"}, {31'd0, popped1.size() >= n}, 1);
    for (int i = 0; i < n && i < popped1.size(); i++) begin
      chk($sformatf("%s[%0d] relu1", tag, i), popped1[i], want1[i]);
      chk($sformatf("%s[%0d] relu0", tag, i), popped0[i], want0[i]);
    end
  endtask

  task automatic load_ramp();
    stim.delete();
    for (int i = 1; i <= LEN; i++) stim.push_back(16'(i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    total = 0; fails = 0; pos = 0; accepted = 0;
    do_reset();
    tick();  // reset state: ready=1, valid=0, data=0

    // Ramp 1..15, downstream always ready.
    load_ramp(); popped1.delete(); popped0.delete();
    run(100, 100, 100, 1); drain(50);
    want1 = '{16'sd2, 16'sd4, 16'sd6, 16'sd8, 16'sd10, 16'sd12, 16'sd14, 16'sd15};
    want0 = want1;
    chk_out("ramp", OUTS);
    chk("ramp output count", popped1.size(), OUTS);

    // Mixed signs, then filler to finish the vector.
    stim = '{-16'sd5, -16'sd3, 16'sd7, -16'sd1, -16'sd8, -16'sd2};
    for (int i = 0; i < LEN - 6; i++) stim.push_back(16'(i));
    popped1.delete(); popped0.delete();
    run(100, 100, 100, 1); drain(50);
    want1 = '{16'sd0, 16'sd7, 16'sd0};
    want0 = '{-16'sd3, 16'sd7, -16'sd2};
    chk_out("relu", 3);

    // Full-range signed extremes.
    stim = '{16'sh8000, 16'sh7fff, 16'sh8000, 16'sh8001};
    for (int i = 0; i < LEN - 4; i++) stim.push_back(16'sd0);
    popped1.delete(); popped0.delete();
    run(100, 100, 100, 1); drain(50);
    want1 = '{16'sh7fff, 16'sd0};
    want0 = '{16'sh7fff, 16'sh8001};
    chk_out("extremes", 2);

    // Backpressure: downstream stalled, source always valid.
    load_ramp(); popped1.delete(); popped0.delete();
    accepted = 0;
    run(20, 100, 0, 0);
    chk("bp accepted", accepted, 9);
    chk("bp s_ready_x low", {31'd0, if1.s_ready_x}, 0);
    chk("bp m_valid_y high", {31'd0, if1.m_valid_y}, 1);
    run(100, 100, 100, 1); drain(50);
    want1 = '{16'sd2, 16'sd4, 16'sd6, 16'sd8, 16'sd10, 16'sd12, 16'sd14, 16'sd15};
    want0 = want1;
    chk_out("bp", OUTS);
    chk("bp output count", popped1.size(), OUTS);

    // Random handshakes over 20 back-to-back vectors.
    stim.delete();
    for (int i = 0; i < 20 * LEN; i++) stim.push_back(16'($urandom));
    popped1.delete(); popped0.delete();
    run(4000, 70, 60, 1); drain(200);
    chk("random output count", popped1.size(), 20 * OUTS);

    // Reset mid-vector discards partial window and queued results.
    load_ramp();
    run(5, 100, 0, 0);
    stim.delete();
    do_reset();
    out_ready = 1'b1;
    tick();  // m_valid_y must be low right after reset
    load_ramp(); popped1.delete(); popped0.delete();
    run(100, 100, 100, 1); drain(50);
    want1 = '{16'sd2, 16'sd4, 16'sd6, 16'sd8, 16'sd10, 16'sd12, 16'sd14, 16'sd15};
    want0 = want1;
    chk_out("post reset", OUTS);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
